pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: drives a single-outstanding imem request stream,
// buffers responses in a 2-entry {instr, pc} FIFO and handles branch redirects.
module pc_sequencer #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC   = 32'h0000_0004
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        br_valid_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        flush_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] drain_addr, drain_addr_next;
   logic [1:0]  count, count_next;
   logic        head, head_next;
   logic        tail;

   logic [31:0] fifo_instr [2];
   logic [31:0] fifo_pc    [2];

   logic        redirect;
   logic        misaligned;
   logic [31:0] target;
   logic        req;
   logic        ack;
   logic        push;
   logic        pop;

   assign redirect   = br_valid_i & br_taken_i;
   assign misaligned = (br_addr_i[1:0] != 2'b00);
   assign target     = misaligned ? TRAP_VEC : br_addr_i;

   assign req  = (state == S_FETCH) || (state == S_DRAIN);
   // An ack only counts while a request is actually on the bus.
   assign ack  = imem_ack_i & req;
   assign push = (state == S_FETCH) & ack & ~redirect;
   assign pop  = (count != 2'd0) & instr_ready_i;
   assign tail = head ^ count[0];

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      drain_addr_next = drain_addr;
      count_next      = count;
      head_next       = head;

      case ({push, pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
      if (pop) begin
         head_next = ~head;
      end

      case (state)
         S_FETCH: begin
            if (ack) begin
               pc_next    = pc + 32'd4;
               state_next = (count_next >= 2'd2) ? S_WAIT : S_FETCH;
            end
         end
         S_WAIT: begin
            if (count_next <= 2'd1) begin
               state_next = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (ack) begin
               state_next = S_FETCH;
            end
         end
         default: state_next = S_FETCH;
      endcase

      // A redirect discards everything buffered; an in-flight fetch that has not
      // completed keeps its old address on the bus until its ack is swallowed.
      if (redirect) begin
         count_next = 2'd0;
         head_next  = 1'b0;
         pc_next    = target;
         case (state)
            S_FETCH: begin
               if (ack) begin
                  state_next = S_FETCH;
               end else begin
                  state_next      = S_DRAIN;
                  drain_addr_next = pc;
               end
            end
            S_WAIT:  state_next = S_FETCH;
            S_DRAIN: state_next = ack ? S_FETCH : S_DRAIN;
            default: state_next = S_FETCH;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_FETCH;
         pc         <= RESET_ADDR;
         drain_addr <= RESET_ADDR;
         count      <= 2'd0;
         head       <= 1'b0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         drain_addr <= drain_addr_next;
         count      <= count_next;
         head       <= head_next;
      end
   end

   // NOTE: FIFO storage is not reset; count gates visibility, so stale contents never escape.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_instr[tail] <= imem_rdata_i;
         fifo_pc[tail]    <= pc;
      end
   end

   assign imem_req_o    = req & ~rst_i;
   assign imem_addr_o   = (state == S_DRAIN) ? drain_addr : pc;
   assign instr_valid_o = (count != 2'd0) & ~rst_i;
   assign instr_o       = instr_valid_o ? fifo_instr[head] : 32'd0;
   assign instr_pc_o    = instr_valid_o ? fifo_pc[head]    : 32'd0;
   assign flush_o       = redirect & ~rst_i;
   assign misalign_o    = redirect & misaligned & ~rst_i;

endmodule
